// File: rtl/cheby_eval_fx.sv
// -----------------------------------------------------------------------------
// cheby_eval_fx
//   Evaluates p(x) = sum c[k]*x^k by Horner's rule in signed fixed point.
//   One operand is in flight at a time. A run of degree d loads acc = c[d] at
//   acceptance and then spends d cycles in CALC. The result is held in DONE
//   until the consumer takes it.
//   Each Horner step is acc = sat(((acc*x) >>> FRAC) + c[k]).
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready        operand handshake
//   in_data, in_deg, in_tag  x, requested degree (clamped to DEG), sideband tag
//   out_valid/out_ready      result handshake
//   out_data, out_tag        p(x) and the tag captured at acceptance
//   coef_we/addr/wdata       coefficient write port; applied only while idle
//   coef_ack                 one-cycle pulse after an applied write
// -----------------------------------------------------------------------------
module cheby_eval_fx #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int DEG   = 4,
  parameter int TAG_W = 4,
  localparam int AW   = ((DEG + 1) > 1) ? $clog2(DEG + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [AW-1:0]    in_deg,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [W-1:0]     coef_wdata,
  output logic             coef_ack
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [AW-1:0] DEG_A = AW'(DEG);

  // Saturation bounds expressed at the width of the unclamped sum.
  localparam logic signed [2*W:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  state_t               r_state;
  state_t               w_state_next;
  logic [W-1:0]         r_coef [0:DEG];
  logic signed [W-1:0]  r_acc;
  logic signed [W-1:0]  r_x;
  logic [AW-1:0]        r_k;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_coef_ack;

  logic                 w_accept;
  logic                 w_coef_wr;
  logic [AW-1:0]        w_deg;
  logic [W-1:0]         w_coef_rd;
  logic signed [2*W-1:0] w_acc_ext;
  logic signed [2*W-1:0] w_x_ext;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_shift;
  logic signed [2*W:0]   w_sum;
  logic signed [W-1:0]   w_sat;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_coef_wr = coef_we && (r_state == S_IDLE) && (coef_addr <= DEG_A);
  assign w_deg     = (in_deg > DEG_A) ? DEG_A : in_deg;

  // Horner step datapath. Both operands are sign-extended to 2W bits first,
  // so the product is exact. The sum carries one extra bit, so it cannot wrap
  // before it is clamped.
  assign w_coef_rd = r_coef[r_k];
  assign w_acc_ext = {{W{r_acc[W-1]}}, r_acc};
  assign w_x_ext   = {{W{r_x[W-1]}}, r_x};
  assign w_prod    = w_acc_ext * w_x_ext;
  assign w_shift   = w_prod >>> FRAC;
  assign w_sum     = {w_shift[2*W-1], w_shift} + {{(W+1){w_coef_rd[W-1]}}, w_coef_rd};

  always_comb begin
    if (w_sum > SAT_MAX) begin
      w_sat = {1'b0, {(W-1){1'b1}}};
    end else if (w_sum < SAT_MIN) begin
      w_sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      w_sat = w_sum[W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = (w_deg == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_k == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and coefficient storage. On the acceptance edge the acc load
  // reads r_coef before any write on that same edge lands. Later CALC reads
  // see the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DEG; i++) begin
        r_coef[i] <= '0;
      end
      r_acc      <= '0;
      r_x        <= '0;
      r_k        <= '0;
      r_tag      <= '0;
      r_coef_ack <= 1'b0;
    end else begin
      r_coef_ack <= w_coef_wr;
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_wdata;
      end
      if (w_accept) begin
        r_x   <= in_data;
        r_tag <= in_tag;
        r_acc <= r_coef[w_deg];
        r_k   <= (w_deg == '0) ? '0 : (w_deg - AW'(1));
      end else if (r_state == S_CALC) begin
        r_acc <= w_sat;
        if (r_k != '0) begin
          r_k <= r_k - AW'(1);
        end
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_acc;
  assign out_tag   = r_tag;
  assign coef_ack  = r_coef_ack;

endmodule

// File: doc/cheby_eval_fx.md
CHEBY_EVAL_FX -- requirements
Module: cheby_eval_fx

Interface
REQ-001 SHALL have parameter W, default 16: signed fixed-point data/coefficient width.
REQ-002 SHALL have parameter FRAC, default 12: fractional bits (Q(W-FRAC).FRAC; 1.0 = 0x1000).
REQ-003 SHALL have parameter DEG, default 4: maximum polynomial degree.
REQ-004 SHALL have parameter TAG_W, default 4: sideband tag width.
REQ-005 SHALL have derived parameter AW = clog2(DEG+1), minimum 1: coefficient address width.
REQ-006 SHALL use one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-007 SHALL have ports, name direction width meaning:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid is also high.
- in_data  in  W  signed x.
- in_deg  in  AW  run-time degree d for this operand.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  W  signed p(x).
- out_tag  out  TAG_W  tag captured at acceptance.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index k.
- coef_wdata  in  W  signed c[k].
- coef_ack  out  1  one-cycle pulse: the previous-cycle write was applied.

Function
REQ-008 SHALL hold DEG+1 W-bit coefficient registers c[0..DEG].
REQ-009 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-010 SHALL drive in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-011 On acceptance, SHALL perform all of the following:
- capture x, out_tag, and d = min(in_deg, DEG);
- load acc = c[d] and step counter k = d-1;
- go to CALC if d>0, else go to DONE.
REQ-012 Each CALC cycle SHALL compute acc = sat(((acc*x) >>> FRAC) + c[k]).
- The product is a full 2W-bit signed value.
- >>> is an arithmetic shift that truncates toward minus infinity.
- The sum is formed without overflow before saturation.
- sat clamps to the range [-2^(W-1), 2^(W-1)-1].
REQ-013 CALC SHALL decrement k each cycle and go to DONE after the step that uses c[0].
REQ-014 out_valid SHALL first be high after exactly d+1 rising edges, counting the acceptance edge.
REQ-015 out_data SHALL equal acc, and out_data/out_tag SHALL be stable while out_valid is high and out_ready is low.
REQ-016 In DONE with out_ready high, the block SHALL go to IDLE at the edge.
- in_ready is low throughout DONE; there is no overlap of operands.
- Minimum issue interval is d+2 cycles.
REQ-017 Coefficient writes SHALL be applied only when state==IDLE and coef_addr <= DEG.
- Any other write is dropped with no coef_ack pulse.
REQ-018 A write applied on the acceptance edge SHALL follow these rules:
- it is not seen by the acc load of c[d], which uses the pre-edge value;
- it is seen by later CALC reads of c[k], k<d.
REQ-019 in_valid held without a handshake SHALL have no effect, and in_data changes while in_ready is low SHALL be ignored.

Reset
REQ-020 When rst is high at an edge, the block SHALL, from any state including mid-CALC:
- go to IDLE;
- clear all c[k], acc, k, out_data and out_tag to 0;
- set coef_ack to 0.
REQ-021 During and after reset, in_ready SHALL be 1 and out_valid 0 in the first cycle after the reset edge.
REQ-022 An operation in flight SHALL be discarded on reset and produce no result.

Verification
REQ-023 Bench SHALL cover, with W=16, FRAC=12, DEG=4, coefficients c = {0x1000, 0x1000, 0x0800, 0x02AB, 0x00AB} loaded at indices 0..4, the following scenarios:
- x=0x0000, d=4, tag=0x3 -> out_data 0x1000, out_tag 0x3; out_valid first high 5 edges after acceptance.
- x=0x1000, d=1 -> 0x2000 after 2 edges. x=0xF000, d=2 -> 0x0800.
- All c[k]=0x7FFF, x=0x7FFF, d=2 -> 0x7FFF (saturated). All c[k]=0x8000, x=0x7FFF, d=1 -> 0x8000.
- out_ready held low 3 cycles in DONE -> out_data/out_tag unchanged and in_ready 0. Write during CALC -> no coef_ack, coefficient unchanged.
- in_deg=7 -> clamped to d=4, latency 5. d=0 -> out_data=c[0] after 1 edge.
- rst asserted on the 2nd CALC cycle -> next cycle in_ready 1, out_valid 0, all c[k]=0; a following d=4 request returns 0x0000.
